// File: rtl/regfile_32x32.sv
// regfile_32x32: 32-entry register file with two asynchronous read ports and
// one synchronous write port. Register 0 always reads zero.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears every register on the edge
//   RegWrite       write enable
//   WriteRegister  write address (5 bits)
//   WriteData      write data
//   ReadRegister1  read port 1 address
//   ReadRegister2  read port 2 address
//   ReadData1      read port 1 data (combinational)
//   ReadData2      read port 2 data (combinational)
//
// Parameters:
//   WIDTH   data width of each register
//   BYPASS  1: a read of the register being written this cycle returns
//           WriteData; 0: it returns the stored value until the edge
module regfile_32x32 #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  // Register 0 has no storage; only entries 1..31 exist.
  logic [WIDTH-1:0] regs_q [1:31];
  logic [WIDTH-1:0] regs_d [1:31];

  // One-hot write enable; bit 0 would be ignored, so it is never built.
  logic [31:1] en;

  always_comb begin
    en = '0;
    for (int i = 1; i < 32; i++) begin
      en[i] = RegWrite && (WriteRegister == 5'(i));
    end
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (en[i]) begin
        regs_d[i] = WriteData;
      end
    end
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports
  logic [4:0]       raddr [2];
  logic [WIDTH-1:0] rdata [2];

  assign raddr[0]  = ReadRegister1;
  assign raddr[1]  = ReadRegister2;
  assign ReadData1 = rdata[0];
  assign ReadData2 = rdata[1];

  for (genvar p = 0; p < 2; p++) begin : g_rport
    logic hit_wr;

    // Bypass is independent of reset and never applies to address 0.
    assign hit_wr = BYPASS && RegWrite && (WriteRegister != 5'd0) &&
                    (raddr[p] == WriteRegister);

    always_comb begin
      rdata[p] = '0;
      if (raddr[p] != 5'd0) begin
        if (hit_wr) begin
          rdata[p] = WriteData;
        end else begin
          rdata[p] = regs_q[raddr[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_32x32.sv
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] rd1_nb, rd2_nb, rd1_by, rd2_by;

  always #5 clk = ~clk;

  regfile_32x32 #(.WIDTH(32), .BYPASS(1'b0)) u_dut_nb (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (rd1_nb),
    .ReadData2     (rd2_nb)
  );

  regfile_32x32 #(.WIDTH(32), .BYPASS(1'b1)) u_dut_by (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (rd1_by),
    .ReadData2     (rd2_by)
  );

  typedef struct {
    logic [31:0] rd1_nb;
    logic [31:0] rd2_nb;
    logic [31:0] rd1_by;
    logic [31:0] rd2_by;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [32];

  // Reference: reg 0 is zero; bypass only with BYPASS=1, write enabled,
  // matching nonzero address.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && RegWrite && a == WriteRegister) return WriteData;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: read data is combinational, so outputs are presented every cycle;
  // sample on the falling edge, away from the write edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, ".rd1_nb"}, rd1_nb, e.rd1_nb);
      check({e.tag, ".rd2_nb"}, rd2_nb, e.rd2_nb);
      check({e.tag, ".rd1_by"}, rd1_by, e.rd1_by);
      check({e.tag, ".rd2_by"}, rd2_by, e.rd2_by);
    end
  end

  // One cycle: drive inputs after a rising edge, queue the expectation for the
  // pre-edge read, then update the model on the next edge.
  task automatic cycle(input string tag, input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = ra1; ReadRegister2 = ra2;
    e.rd1_nb = ref_read(ra1, 1'b0);
    e.rd2_nb = ref_read(ra2, 1'b0);
    e.rd1_by = ref_read(ra1, 1'b1);
    e.rd2_by = ref_read(ra2, 1'b1);
    e.tag    = tag;
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
    reset = 1'b0; RegWrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    cycle(tag, 1'b0, 1'b0, 5'd0, $urandom, a1, a2);
  endtask

  initial begin
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Only address 0 is defined before the first reset.
    cycle("reset", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) rd("reset_sweep", 5'(a), 5'(31 - a));

    cycle("wr14", 1'b0, 1'b1, 5'd14, 32'hDEADBEEF, 5'd14, 5'd13);
    rd("rd14_13", 5'd14, 5'd13);
    rd("rd13_15", 5'd13, 5'd15);

    cycle("gate_off", 1'b0, 1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
    rd("gate_off_rd", 5'd7, 5'd7);
    cycle("gate_on", 1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd14);
    rd("gate_on_rd", 5'd7, 5'd14);

    cycle("wr0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    rd("rd0", 5'd0, 5'd14);

    for (int i = 1; i < 32; i++)
      cycle("uniq_wr", 1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101 + 32'h1, 5'(i), 5'(i - 1));
    for (int i = 0; i < 32; i++) rd("uniq_rd", 5'(i), 5'(i));

    cycle("wr5", 1'b0, 1'b1, 5'd5, 32'hAAAA5555, 5'd5, 5'd4);
    cycle("rst_prio", 1'b1, 1'b1, 5'd5, 32'h11111111, 5'd5, 5'd9);
    rd("rst_prio_rd", 5'd5, 5'd31);

    cycle("byp9", 1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd3);
    rd("byp9_after", 5'd9, 5'd9);

    // Random traffic with occasional resets, including bypass-under-reset.
    for (int n = 0; n < 400; n++) begin
      cycle("rand", ($urandom_range(0, 29) == 0), $urandom_range(0, 1), 5'($urandom),
            $urandom, 5'($urandom), 5'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bound the run in case a wait never returns.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
